// File: rtl/spi_scaler_fb_if.sv
// Pixel bus between the SPI receiver, the frame store and the video line generator.
interface spi_scaler_fb_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned ROW_W = 10
);
  logic             clk_SPI;
  logic [PIX_W:0]   Data;
  logic             freeze;
  logic             Next_Line;
  logic [ROW_W-1:0] Row_Select;
  logic [PIX_W-1:0] Data_O;
  logic             Data_Valid;
  logic             Line_Done;
  logic             Frame_Ready;
  logic             Overflow;

  modport master (
    output clk_SPI, Data, freeze, Next_Line, Row_Select,
    input  Data_O, Data_Valid, Line_Done, Frame_Ready, Overflow
  );

  modport slave (
    input  clk_SPI, Data, freeze, Next_Line, Row_Select,
    output Data_O, Data_Valid, Line_Done, Frame_Ready, Overflow
  );
endinterface

// File: rtl/spi_scaler_fb.sv
// Double-buffered native-resolution frame store; streams integer-upscaled lines
// on request and swaps completed frames only between lines.
module spi_scaler_fb #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned SRC_COLS   = 160,
  parameter int unsigned SRC_ROWS   = 120,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned ROW_W      = 10
) (
  input  logic          CLK,
  input  logic          reset_n,
  spi_scaler_fb_if.slave bus
);

  localparam int unsigned FRAME  = SRC_COLS * SRC_ROWS;
  localparam int unsigned DEPTH  = 2 * FRAME;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = $clog2(SRC_COLS + 1);
  localparam int unsigned RW     = $clog2(SRC_ROWS + 1);
  localparam int unsigned LINE_N = SRC_COLS << SCALE_LOG2;
  localparam int unsigned NW     = $clog2(LINE_N + 1);

  typedef enum logic {W_FILL, W_DONE} wr_state_t;
  typedef enum logic {R_IDLE, R_RUN}  rd_state_t;

  wr_state_t        wr_state, wr_state_nxt;
  rd_state_t        rd_state, rd_state_nxt;

  logic [2:0]       spi_sync;
  logic             wr_ev_c, sof_c;
  logic [PIX_W-1:0] pix_c;
  logic [CW-1:0]    wr_col;
  logic [RW-1:0]    wr_row;
  logic [AW-1:0]    wr_row_base;
  logic             col_wrap_c, last_pix_c;
  logic             we_c, ovf_set_c, frame_done_c;
  logic [AW-1:0]    back_base_c, wr_addr_c;

  logic             front_bank, swap_pending, frame_ready, overflow;
  logic             swap_c;

  logic [ROW_W-1:0] row_sel_src_c;
  logic [ROW_W-1:0] src_row;
  logic [AW-1:0]    rd_row_base;
  logic [NW-1:0]    rd_cnt;
  logic             issue_c, last_issue_c, blank_c;
  logic [AW-1:0]    front_base_c, rd_addr_c;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_q;
  logic             s1_v, s1_last, s1_blank;
  logic [PIX_W-1:0] data_o_q;
  logic             data_valid_q, line_done_q;

  // Strobe synchroniser plus one extra flop for rising-edge detection
  always_ff @(posedge CLK) begin
    if (!reset_n) spi_sync <= '0;
    else          spi_sync <= {spi_sync[1:0], bus.clk_SPI};
  end

  assign wr_ev_c    = spi_sync[1] & ~spi_sync[2];
  assign sof_c      = bus.Data[PIX_W];
  assign pix_c      = bus.Data[PIX_W-1:0];
  assign col_wrap_c = (wr_col == CW'(SRC_COLS - 1));
  assign last_pix_c = col_wrap_c && (wr_row == RW'(SRC_ROWS - 1));

  always_ff @(posedge CLK) begin
    if (!reset_n) wr_state <= W_FILL;
    else          wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    if (wr_ev_c) begin
      if (sof_c)
        wr_state_nxt = W_FILL;
      else if (wr_state == W_FILL && last_pix_c)
        wr_state_nxt = W_DONE;
    end
  end

  always_comb begin
    we_c         = 1'b0;
    ovf_set_c    = 1'b0;
    frame_done_c = 1'b0;
    back_base_c  = front_bank ? '0 : AW'(FRAME);
    wr_addr_c    = back_base_c + (sof_c ? '0 : wr_row_base + AW'(wr_col));
    if (wr_ev_c) begin
      if (sof_c) begin
        we_c = 1'b1;
      end else if (wr_state == W_FILL) begin
        we_c         = 1'b1;
        frame_done_c = last_pix_c;
      end else begin
        ovf_set_c = 1'b1;
      end
    end
  end

  // Write pointer; the row base steps by SRC_COLS so no multiplier is needed
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      wr_col      <= '0;
      wr_row      <= '0;
      wr_row_base <= '0;
    end else if (wr_ev_c) begin
      if (sof_c) begin
        wr_col      <= CW'(1);
        wr_row      <= '0;
        wr_row_base <= '0;
      end else if (wr_state == W_FILL) begin
        if (col_wrap_c) begin
          wr_col <= '0;
          if (last_pix_c) begin
            wr_row      <= '0;
            wr_row_base <= '0;
          end else begin
            wr_row      <= wr_row + RW'(1);
            wr_row_base <= wr_row_base + AW'(SRC_COLS);
          end
        end else begin
          wr_col <= wr_col + CW'(1);
        end
      end
    end
  end

  // A same-cycle SOF discards the pending frame instead of exposing a bank mid-write
  assign swap_c = swap_pending & ~bus.freeze & (rd_state == R_IDLE) & ~(wr_ev_c & sof_c);

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      frame_ready  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (swap_c) begin
        front_bank  <= ~front_bank;
        frame_ready <= 1'b1;
      end
      if (wr_ev_c && sof_c)
        swap_pending <= 1'b0;
      else if (frame_done_c)
        swap_pending <= 1'b1;
      else if (swap_c)
        swap_pending <= 1'b0;
      if (ovf_set_c)
        overflow <= 1'b1;
    end
  end

  // Simple dual-port RAM, registered read, contents not reset
  always_ff @(posedge CLK) begin
    if (we_c) mem[wr_addr_c] <= pix_c;
    rd_q <= mem[rd_addr_c];
  end

  assign row_sel_src_c = bus.Row_Select >> SCALE_LOG2;

  always_ff @(posedge CLK) begin
    if (!reset_n) rd_state <= R_IDLE;
    else          rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (bus.Next_Line) rd_state_nxt = R_RUN;
      R_RUN:   if (last_issue_c)  rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    issue_c      = (rd_state == R_RUN);
    last_issue_c = issue_c && (rd_cnt == NW'(LINE_N - 1));
    blank_c      = (src_row >= ROW_W'(SRC_ROWS)) | ~frame_ready;
    front_base_c = front_bank ? AW'(FRAME) : '0;
    rd_addr_c    = blank_c ? '0 : front_base_c + rd_row_base + AW'(rd_cnt >> SCALE_LOG2);
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      src_row     <= '0;
      rd_row_base <= '0;
      rd_cnt      <= '0;
    end else if (rd_state == R_IDLE && bus.Next_Line) begin
      src_row     <= row_sel_src_c;
      rd_row_base <= AW'(32'(row_sel_src_c) * SRC_COLS);
      rd_cnt      <= '0;
    end else if (issue_c) begin
      rd_cnt <= rd_cnt + NW'(1);
    end
  end

  // Two-stage output pipeline aligned with the registered RAM read
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      s1_v         <= 1'b0;
      s1_last      <= 1'b0;
      s1_blank     <= 1'b0;
      data_valid_q <= 1'b0;
      line_done_q  <= 1'b0;
      data_o_q     <= '0;
    end else begin
      s1_v         <= issue_c;
      s1_last      <= last_issue_c;
      s1_blank     <= blank_c;
      data_valid_q <= s1_v;
      line_done_q  <= s1_last;
      data_o_q     <= (s1_v && !s1_blank) ? rd_q : '0;
    end
  end

  assign bus.Data_O      = data_o_q;
  assign bus.Data_Valid  = data_valid_q;
  assign bus.Line_Done   = line_done_q;
  assign bus.Frame_Ready = frame_ready;
  assign bus.Overflow    = overflow;

endmodule

// File: tb/tb_spi_scaler_fb.sv
// Randomised bench for spi_scaler_fb against a frame-level reference model.
module tb_spi_scaler_fb;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 3;
  localparam int unsigned SL    = 1;
  localparam int unsigned ROW_W = 10;
  localparam int unsigned N     = COLS << SL;
  localparam int unsigned FR    = COLS * ROWS;

  logic CLK = 1'b0;
  logic reset_n;

  spi_scaler_fb_if #(.PIX_W(PIX_W), .ROW_W(ROW_W)) bus ();

  spi_scaler_fb #(
    .PIX_W(PIX_W), .SRC_COLS(COLS), .SRC_ROWS(ROWS), .SCALE_LOG2(SL), .ROW_W(ROW_W)
  ) dut (
    .CLK(CLK),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model: displayed frame, frame being assembled, flags
  logic [7:0] m_front [FR];
  logic [7:0] m_back  [FR];
  int  m_idx;
  bit  m_done, m_pend, m_ready, m_ovf, m_freeze, m_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_done = 0; m_pend = 0; m_ready = 0; m_ovf = 0; m_busy = 0;
  endtask

  task automatic model_write(input logic [7:0] pix, input bit sof);
    if (sof) begin
      m_back[0] = pix; m_idx = 1; m_done = 0; m_pend = 0;
    end else if (m_done) begin
      m_ovf = 1;
    end else begin
      m_back[m_idx] = pix;
      m_idx++;
      if (m_idx == FR) begin
        m_idx = 0; m_done = 1; m_pend = 1;
      end
    end
  endtask

  task automatic model_sync();
    logic [7:0] tmp [FR];
    if (m_pend && !m_freeze && !m_busy) begin
      tmp = m_front; m_front = m_back; m_back = tmp;
      m_pend = 0; m_ready = 1;
    end
  endtask

  task automatic spi_write(input logic [7:0] pix, input bit sof);
    @(negedge CLK);
    bus.Data    = {sof, pix};
    bus.clk_SPI = 1'b1;
    repeat (5) @(negedge CLK);
    bus.clk_SPI = 1'b0;
    repeat (2) @(negedge CLK);
    model_write(pix, sof);
    model_sync();
    check("overflow", 32'(bus.Overflow), 32'(m_ovf));
  endtask

  task automatic write_pixels(input int n, input bit first_sof, input int first_val, input bit rnd);
    for (int i = 0; i < n; i++)
      spi_write(rnd ? 8'($urandom_range(0, 255)) : 8'(first_val + i), first_sof && i == 0);
  endtask

  task automatic set_freeze(input bit v);
    @(negedge CLK);
    bus.freeze = v;
    m_freeze   = v;
    @(negedge CLK);
    model_sync();
  endtask

  // One line request; hold keeps Next_Line high into the run to test that it is ignored
  task automatic do_line(input int row, input bit hold);
    logic [7:0] exp_pix [COLS];
    bit blank;
    int sr;
    bit v;
    model_sync();
    m_busy = 1;
    sr    = row >> SL;
    blank = !m_ready || sr >= int'(ROWS);
    for (int c = 0; c < int'(COLS); c++)
      exp_pix[c] = blank ? 8'd0 : m_front[sr * int'(COLS) + c];
    @(negedge CLK);
    bus.Next_Line  = 1'b1;
    bus.Row_Select = ROW_W'(row);
    @(negedge CLK);
    if (!hold) bus.Next_Line = 1'b0;
    for (int k = 1; k <= int'(N) + 2; k++) begin
      @(negedge CLK);
      if (k == 2) bus.Next_Line = 1'b0;
      v = (k >= 2) && (k <= int'(N) + 1);
      if (k == 1) check("frame_ready", 32'(bus.Frame_Ready), 32'(m_ready));
      check("data_valid", 32'(bus.Data_Valid), 32'(v));
      check("line_done", 32'(bus.Line_Done), 32'(k == int'(N) + 1));
      if (v) check("data_o", 32'(bus.Data_O), 32'(exp_pix[(k - 2) >> SL]));
    end
    m_busy = 0;
    model_sync();
  endtask

  task automatic reset_mid_line();
    @(negedge CLK);
    bus.Next_Line  = 1'b1;
    bus.Row_Select = ROW_W'(0);
    @(negedge CLK);
    bus.Next_Line = 1'b0;
    repeat (3) @(negedge CLK);
    reset_n = 1'b0;
    @(negedge CLK);
    check("rst_data_valid", 32'(bus.Data_Valid), 32'd0);
    check("rst_line_done", 32'(bus.Line_Done), 32'd0);
    check("rst_frame_ready", 32'(bus.Frame_Ready), 32'd0);
    check("rst_overflow", 32'(bus.Overflow), 32'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.clk_SPI    = 1'b0;
    bus.Data       = '0;
    bus.freeze     = 1'b0;
    bus.Next_Line  = 1'b0;
    bus.Row_Select = '0;
    m_freeze       = 0;
    for (int i = 0; i < int'(FR); i++) begin
      m_front[i] = '0; m_back[i] = '0;
    end
    model_reset();
    repeat (3) @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    check("reset_data_valid", 32'(bus.Data_Valid), 32'd0);
    check("reset_line_done", 32'(bus.Line_Done), 32'd0);
    check("reset_frame_ready", 32'(bus.Frame_Ready), 32'd0);
    check("reset_overflow", 32'(bus.Overflow), 32'd0);
    check("reset_data_o", 32'(bus.Data_O), 32'd0);

    // No frame yet: zeros
    do_line(2, 0);
    // Basic frame 1..12, row 2 -> source row 1
    write_pixels(12, 1, 1, 0);
    do_line(2, 0);
    // Out-of-range row
    do_line(6, 0);
    // Last pixel of frame 101..112 lands during a line: swap waits for the line end
    write_pixels(11, 1, 101, 0);
    fork
      do_line(0, 0);
      begin
        @(negedge CLK);
        spi_write(8'd112, 0);
      end
    join
    do_line(0, 0);
    // Freeze holds the displayed bank
    set_freeze(1);
    write_pixels(12, 1, 201, 0);
    do_line(1, 0);
    set_freeze(0);
    do_line(1, 0);
    // Early SOF abandons a partial frame
    write_pixels(5, 1, 50, 0);
    write_pixels(3, 1, 60, 0);
    do_line(4, 0);
    // Complete frame then an extra pixel without SOF -> overflow, data unchanged
    write_pixels(12, 1, 70, 0);
    spi_write(8'd99, 0);
    do_line(3, 1);
    do_line(5, 0);
    // Reset in the middle of a line
    reset_mid_line();
    do_line(2, 0);

    // Randomised mix of frames, partial frames, stray pixels, freeze and lines
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0:       write_pixels(12, 1, 0, 1);
        1:       write_pixels(int'($urandom_range(1, 11)), 1, 0, 1);
        2:       spi_write(8'($urandom_range(0, 255)), 0);
        3:       set_freeze(bit'($urandom_range(0, 1)));
        default: do_line(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      endcase
    end
    set_freeze(0);
    write_pixels(12, 1, 0, 1);
    for (int r = 0; r < 8; r++) do_line(r, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_scaler_fb.md
# spi_scaler_fb

Parametrised, double-buffered frame store between the SPI pixel receiver and the video line generator. It stores one native-resolution source frame per bank and never duplicates pixels in memory. On each video line request it streams a source row with horizontal and vertical integer upscaling by 2^SCALE_LOG2. Completed frames swap to the display bank only between lines, so a line never tears.

## Interface
- PIX_W, 8, pixel width
- SRC_COLS, 160, source pixels per row
- SRC_ROWS, 120, source rows per frame
- SCALE_LOG2, 2, upscale factor = 1<<SCALE_LOG2 (0..3)
- ROW_W, 10, Row_Select width

Ports:
- CLK  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- clk_SPI  in  1  pixel strobe from SPI side, asynchronous to CLK
- Data  in  PIX_W+1  [PIX_W-1:0] pixel, [PIX_W] start-of-frame (SOF) flag
- freeze  in  1  1 = hold displayed bank, no swaps
- Next_Line  in  1  one-cycle line request
- Row_Select  in  ROW_W  output (scaled) row index, sampled with Next_Line
- Data_O  out  PIX_W  output pixel
- Data_Valid  out  1  Data_O valid
- Line_Done  out  1  one-cycle pulse with last pixel of a line
- Frame_Ready  out  1  at least one frame has been displayed since reset
- Overflow  out  1  sticky: pixel dropped

## Operation
- Write side:
  - clk_SPI passes through a 2-flop synchroniser. A rising edge of the synchronised strobe is one write event.
  - Data is sampled in that same cycle. Data must be stable at least 3 CLK cycles after the clk_SPI edge.
- Write FSM states are FILL and DONE. Pointer wr_row/wr_col writes into the back bank.
  - SOF in any state: restart at (0,0) in the back bank, write the pixel, set wr_col=1, enter FILL. Clear swap_pending. A partial frame is abandoned and no swap occurs.
  - FILL, no SOF: write, then wr_col++. At SRC_COLS-1, wr_col wraps to 0 and wr_row++. Writing (SRC_ROWS-1, SRC_COLS-1) sets swap_pending and enters DONE.
  - DONE, no SOF: pixel dropped, Overflow<=1.
- Swap occurs when swap_pending=1, freeze=0 and the read FSM is IDLE. On swap, front/back toggle, swap_pending clears and Frame_Ready<=1.
  - With freeze=1 the pending frame is held until freeze falls, or until it is discarded by the next SOF.
- Memory: one simple dual-port RAM of 2*SRC_ROWS*SRC_COLS x PIX_W with 1-cycle registered read.
  - Write address uses a running row base (+SRC_COLS per row), with no multiplier.
- Read FSM states are IDLE and RUN.
  - IDLE with Next_Line: latch src_row = Row_Select>>SCALE_LOG2 and enter RUN.
  - RUN: issue SRC_COLS<<SCALE_LOG2 reads. Each source column is repeated 1<<SCALE_LOG2 consecutive cycles.
  - After the last issue, return to IDLE.
  - If src_row>=SRC_ROWS or Frame_Ready=0, the line still runs full length but Data_O=0.
  - Next_Line while in RUN is ignored.
- Reset values: Data_O=0, Data_Valid=0, Line_Done=0, Frame_Ready=0, Overflow=0, front bank=0, swap_pending=0, pointers 0, write FSM=FILL, read FSM=IDLE. RAM contents are not reset.
- reset_n low mid-line aborts the line. The outputs take their reset values on the next edge.

## Timing
- Next_Line at cycle t gives Data_Valid=1 from t+2 through t+1+N, with N=SRC_COLS<<SCALE_LOG2. Data_Valid stays continuous with no gaps.
- Line_Done=1 only at t+1+N.
- Next_Line is accepted from t+N+1. Issuing it at t+N+1 gives a one-cycle gap between lines.
- A clk_SPI edge reaches the RAM 3–4 CLK cycles after the edge.
- Swap occurs on the first CLK edge where the swap conditions all hold. Worst-case deferral is one line (N+1 cycles).
- The same-address read/write collision cannot occur, because reads use the front bank and writes use the back bank.

## Test plan
Parameters for all scenarios: SRC_COLS=4, SRC_ROWS=3, SCALE_LOG2=1.
- Basic line: write pixels 1..12, SOF on pixel 1, then Next_Line with Row_Select=2 -> Frame_Ready=1 and Data_O=5,5,6,6,7,7,8,8 at t+2..t+9, Line_Done at t+9 only.
- Out-of-range row: Row_Select=6 -> 8 valid cycles of Data_O=0 and Line_Done. Before any frame, any row -> zeros.
- Deferred swap: complete frame 101..112 while a line is running -> that line still reads frame 1 values. The next line with Row_Select=0 -> 101,101,102,102,...
- Freeze: freeze=1, complete frame 2 -> reads still show frame 1. Drop freeze -> the next line shows frame 2.
- Early SOF and overflow: 5 pixels then SOF -> no swap and old frame shown. A 13th pixel without SOF after a complete frame -> Overflow=1 sticky and displayed data unchanged.
- Reset mid-line: reset_n=0 at t+4 of a line -> Data_Valid=0, Frame_Ready=0, Overflow=0 on the next edge. After release, Next_Line -> 8 zeros.
